// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the two-phase toggle handshake (sender and receiver sides).
package toggle_hs_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rx_state_t;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned CNT_W_DEF       = 16;

   // Toggle parity both ends come out of reset with.
   localparam logic TGL_RST = 1'b0;

endpackage : toggle_hs_pkg

// File: rtl/toggle_sync_edge.sv
// Synchronises a toggle into the clk domain and flags each level change for one cycle.
module toggle_sync_edge
   import toggle_hs_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic req_tgl,
   output logic evt_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   req_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= {SYNC_STAGES{TGL_RST}};
         req_prev <= TGL_RST;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], req_tgl};
         req_prev <= req_s;
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];
   assign evt_c = req_s ^ req_prev;

endmodule : toggle_sync_edge

// File: rtl/toggle_handshake_rx.sv
// Receive end of a two-phase toggle handshake: one captured word per req_tgl flip,
// handed to a valid/ready consumer, each acceptance answered by an ack_tgl flip.
module toggle_handshake_rx
   import toggle_hs_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_tgl,
   input  logic [DATA_W-1:0] req_data,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              ack_tgl,
   output logic              err_ovr,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  xfer_cnt,
   output logic [CNT_W-1:0]  ovr_cnt
);

   rx_state_t state;
   logic      evt;
   logic      accept_c;
   logic      ovr_c;

   toggle_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .req_tgl (req_tgl),
      .evt_c   (evt)
   );

   assign accept_c = dout_valid & dout_ready;
   // A new flip while the held word is still unconsumed drops the new word.
   assign ovr_c    = (state == HOLD) & evt & ~accept_c;

   // Handshake FSM with the data register and ack flop it owns.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dout       <= '0;
         dout_valid <= 1'b0;
         ack_tgl    <= TGL_RST;
      end else begin
         case (state)
            IDLE: begin
               if (evt) begin
                  dout       <= req_data;
                  dout_valid <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (accept_c) begin
                  ack_tgl <= ~ack_tgl;
                  if (evt) begin
                     dout <= req_data;
                  end else begin
                     dout_valid <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: begin
               dout_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   // Transfer statistics and the sticky overrun flag; a same-cycle set beats clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xfer_cnt <= '0;
         ovr_cnt  <= '0;
         err_ovr  <= 1'b0;
      end else begin
         if (accept_c) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
         if (ovr_c && (ovr_cnt != {CNT_W{1'b1}})) begin
            ovr_cnt <= ovr_cnt + CNT_W'(1);
         end
         if (ovr_c) begin
            err_ovr <= 1'b1;
         end else if (err_clr) begin
            err_ovr <= 1'b0;
         end
      end
   end

endmodule : toggle_handshake_rx

// File: tb/tb_toggle_handshake_rx.sv
// Scoreboard bench for toggle_handshake_rx, built with a 4-bit counter width.
module tb_toggle_handshake_rx;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_tgl;
   logic [DATA_W-1:0] req_data;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              ack_tgl;
   logic              err_ovr;
   logic              err_clr;
   logic [CNT_W-1:0]  xfer_cnt;
   logic [CNT_W-1:0]  ovr_cnt;

   int                checks = 0;
   int                fails  = 0;
   logic [DATA_W-1:0] sb[$];
   logic [DATA_W-1:0] mon_exp;
   logic              ack_exp  = 1'b0;
   logic [CNT_W-1:0]  xfer_exp = '0;
   logic [CNT_W-1:0]  ovr_exp  = '0;

   always #5 clk = ~clk;

   toggle_handshake_rx #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (2),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_tgl    (req_tgl),
      .req_data   (req_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .ack_tgl    (ack_tgl),
      .err_ovr    (err_ovr),
      .err_clr    (err_clr),
      .xfer_cnt   (xfer_cnt),
      .ovr_cnt    (ovr_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sender side: flip the toggle with new data; queue it only if it should be delivered.
   task automatic send(input logic [DATA_W-1:0] d, input bit deliver);
      req_data = d;
      req_tgl  = ~req_tgl;
      if (deliver) sb.push_back(d);
   endtask

   task automatic chk_ctr(input string tag);
      chk({tag, "_ack"}, 32'(ack_tgl), 32'(ack_exp));
      chk({tag, "_xfer"}, 32'(xfer_cnt), 32'(xfer_exp));
      chk({tag, "_ovr"}, 32'(ovr_cnt), 32'(ovr_exp));
   endtask

   // Acceptance happens at the next rising edge; compare the word handed over.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         ack_exp  = 1'b0;
         xfer_exp = '0;
      end else if (dout_valid && dout_ready) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            chk("sb_data", 32'(dout), 32'(mon_exp));
         end
         ack_exp  = ~ack_exp;
         xfer_exp = xfer_exp + CNT_W'(1);
      end
   end

   initial begin
      reset      = 1'b1;
      req_tgl    = 1'b0;
      req_data   = '0;
      dout_ready = 1'b0;
      err_clr    = 1'b0;
      tick(2);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_err", 32'(err_ovr), 32'd0);
      chk_ctr("rst");
      reset = 1'b0;
      tick(1);

      // single transfer
      dout_ready = 1'b1;
      send(8'hA5, 1'b1);
      tick(2);
      chk("t1_latency", 32'(dout_valid), 32'd0);
      tick(1);
      chk("t1_valid", 32'(dout_valid), 32'd1);
      chk("t1_dout", 32'(dout), 32'hA5);
      tick(1);
      chk("t1_valid_fall", 32'(dout_valid), 32'd0);
      chk("t1_ack", 32'(ack_tgl), 32'd1);
      chk("t1_xfer", 32'(xfer_cnt), 32'd1);

      // backpressure
      dout_ready = 1'b0;
      send(8'h3C, 1'b1);
      tick(3);
      chk("bp_valid", 32'(dout_valid), 32'd1);
      chk("bp_dout", 32'(dout), 32'h3C);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("bp_hold_valid", 32'(dout_valid), 32'd1);
         chk("bp_hold_dout", 32'(dout), 32'h3C);
         chk("bp_hold_ack", 32'(ack_tgl), 32'd1);
      end
      dout_ready = 1'b1;
      tick(1);
      chk("bp_release_valid", 32'(dout_valid), 32'd0);
      chk("bp_release_ack", 32'(ack_tgl), 32'd0);
      chk_ctr("bp");

      // overrun, clear, then set-wins-over-clear
      dout_ready = 1'b0;
      send(8'h11, 1'b1);
      tick(3);
      chk("ovr_hold_dout", 32'(dout), 32'h11);
      send(8'h22, 1'b0);
      ovr_exp = ovr_exp + CNT_W'(1);
      tick(3);
      chk("ovr_dout_kept", 32'(dout), 32'h11);
      chk("ovr_valid", 32'(dout_valid), 32'd1);
      chk("ovr_err", 32'(err_ovr), 32'd1);
      chk("ovr_cnt1", 32'(ovr_cnt), 32'd1);
      chk("ovr_no_ack", 32'(ack_tgl), 32'd0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("ovr_clr", 32'(err_ovr), 32'd0);
      send(8'h33, 1'b0);
      ovr_exp = ovr_exp + CNT_W'(1);
      tick(2);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("ovr_set_wins", 32'(err_ovr), 32'd1);
      chk("ovr_cnt2", 32'(ovr_cnt), 32'd2);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("ovr_clr2", 32'(err_ovr), 32'd0);
      dout_ready = 1'b1;
      tick(1);
      chk("ovr_drain_valid", 32'(dout_valid), 32'd0);
      chk_ctr("ovr_drain");

      // acceptance coinciding with a new event
      dout_ready = 1'b0;
      send(8'h01, 1'b1);
      tick(3);
      chk("sc_hold_dout", 32'(dout), 32'h01);
      send(8'h02, 1'b1);
      tick(2);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      chk("sc_dout", 32'(dout), 32'h02);
      chk("sc_valid", 32'(dout_valid), 32'd1);
      chk("sc_err", 32'(err_ovr), 32'd0);
      chk("sc_ack", 32'(ack_tgl), 32'd0);
      chk_ctr("sc");
      tick(1);
      chk("sc_still_valid", 32'(dout_valid), 32'd1);
      chk("sc_single_ack", 32'(ack_tgl), 32'd0);
      dout_ready = 1'b1;
      tick(1);
      chk("sc_drain_valid", 32'(dout_valid), 32'd0);
      chk_ctr("sc_drain");

      // reset while holding a word
      dout_ready = 1'b0;
      send(8'h5A, 1'b1);
      tick(3);
      chk("mr_valid_pre", 32'(dout_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("mr_valid", 32'(dout_valid), 32'd0);
      chk("mr_dout", 32'(dout), 32'd0);
      chk("mr_ack", 32'(ack_tgl), 32'd0);
      chk("mr_err", 32'(err_ovr), 32'd0);
      chk("mr_xfer", 32'(xfer_cnt), 32'd0);
      chk("mr_ovr", 32'(ovr_cnt), 32'd0);
      req_tgl  = 1'b0;
      req_data = '0;
      ovr_exp  = '0;
      tick(1);
      reset      = 1'b0;
      dout_ready = 1'b1;
      send(8'hC3, 1'b1);
      tick(3);
      chk("mr_rx_valid", 32'(dout_valid), 32'd1);
      chk("mr_rx_dout", 32'(dout), 32'hC3);
      tick(1);
      chk("mr_rx_ack", 32'(ack_tgl), 32'd1);
      chk("mr_rx_xfer", 32'(xfer_cnt), 32'd1);

      // counter wrap and saturation
      reset = 1'b1;
      tick(1);
      req_tgl = 1'b0;
      ovr_exp = '0;
      reset   = 1'b0;
      tick(1);
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(8'($urandom), 1'b1);
         tick(4);
      end
      chk("wrap_xfer", 32'(xfer_cnt), 32'd0);
      dout_ready = 1'b0;
      send(8'($urandom), 1'b1);
      tick(3);
      for (int i = 0; i < 19; i++) begin
         send(8'($urandom), 1'b0);
         if (ovr_exp != {CNT_W{1'b1}}) ovr_exp = ovr_exp + CNT_W'(1);
         tick(3);
      end
      chk("sat_ovr", 32'(ovr_cnt), 32'd15);
      chk("sat_err", 32'(err_ovr), 32'd1);
      dout_ready = 1'b1;
      tick(1);
      chk("sat_drain_valid", 32'(dout_valid), 32'd0);
      chk("sat_xfer", 32'(xfer_cnt), 32'd1);
      chk_ctr("sat");
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule : tb_toggle_handshake_rx
